// File: rtl/ti_adc_offset_cal.sv
// Offset correction back-end for a time-interleaved SAR ADC.
// Subtracts a saturating per-way trim and includes a mean-averaging calibration engine.
module ti_adc_offset_cal #(
    parameter int WAYS  = 8,
    parameter int BITS  = 9,
    parameter int OFFW  = 8,
    parameter int LOG2N = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [WAYS*BITS-1:0]                   adcin,
    input  logic                                   valid_in,
    input  logic                                   bypass,
    output logic [WAYS*BITS-1:0]                   adcout,
    output logic                                   valid_out,
    input  logic                                   cal_start,
    input  logic [BITS-1:0]                        cal_target,
    output logic                                   cal_busy,
    output logic                                   cal_done,
    input  logic                                   off_wr_en,
    input  logic [((WAYS > 1) ? $clog2(WAYS) : 1)-1:0] off_wr_idx,
    input  logic [OFFW-1:0]                        off_wr_data,
    output logic [WAYS*OFFW-1:0]                   off_rd
);

    localparam int IDXW = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int ACCW = BITS + LOG2N;
    // Widths chosen so neither subtraction can wrap before clamping.
    localparam int CW   = (BITS + 2 > OFFW + 2) ? BITS + 2 : OFFW + 2;
    localparam int TW   = (BITS + 2 > OFFW + 1) ? BITS + 2 : OFFW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [LOG2N-1:0]     cnt_reg;
    logic                 last_word;
    logic                 acc_clr;
    logic                 acc_en;
    logic                 load_trims;
    logic                 wr_allowed;
    logic                 cal_done_reg;
    logic                 valid_out_reg;
    logic [WAYS*BITS-1:0] adcout_reg;
    logic [WAYS*BITS-1:0] corr_word;

    assign last_word = valid_in && (&cnt_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cal_start) state_next = ACCUM;
            ACCUM:   if (last_word) state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cal_busy   = (state_reg != IDLE);
        acc_clr    = (state_reg == IDLE) && cal_start;
        acc_en     = (state_reg == ACCUM) && valid_in;
        load_trims = (state_reg == UPDATE);
        wr_allowed = (state_reg == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            cal_done_reg <= 1'b0;
        end else begin
            cal_done_reg <= load_trims;
            if (acc_clr) begin
                cnt_reg <= '0;
            end else if (acc_en) begin
                cnt_reg <= cnt_reg + LOG2N'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : gen_way
            logic [BITS-1:0] code;
            logic [OFFW-1:0] off_reg;
            logic [ACCW-1:0] acc_reg;
            logic [CW-1:0]   diff;
            logic            diff_neg;
            logic            diff_over;
            logic [BITS-1:0] mean;
            logic [TW-1:0]   tdiff;
            logic            tdiff_fits;
            logic [OFFW-1:0] trim_new;

            assign code = adcin[gi*BITS +: BITS];

            assign diff      = {{(CW-BITS){1'b0}}, code} - {{(CW-OFFW){off_reg[OFFW-1]}}, off_reg};
            assign diff_neg  = diff[CW-1];
            assign diff_over = !diff_neg && (|diff[CW-2:BITS]);
            assign corr_word[gi*BITS +: BITS] = diff_neg  ? '0 :
                                                diff_over ? '1 : diff[BITS-1:0];

            // Floored mean minus target; fits OFFW signed iff the upper bits are a pure sign run.
            assign mean       = acc_reg[ACCW-1:LOG2N];
            assign tdiff      = {{(TW-BITS){1'b0}}, mean} - {{(TW-BITS){1'b0}}, cal_target};
            assign tdiff_fits = (&tdiff[TW-1:OFFW-1]) || !(|tdiff[TW-1:OFFW-1]);
            assign trim_new   = tdiff_fits   ? tdiff[OFFW-1:0] :
                                tdiff[TW-1]  ? {1'b1, {(OFFW-1){1'b0}}} :
                                               {1'b0, {(OFFW-1){1'b1}}};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    off_reg <= '0;
                end else if (load_trims) begin
                    off_reg <= trim_new;
                end else if (wr_allowed && off_wr_en && (off_wr_idx == IDXW'(gi))) begin
                    off_reg <= off_wr_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    acc_reg <= '0;
                end else if (acc_clr) begin
                    acc_reg <= '0;
                end else if (acc_en) begin
                    acc_reg <= acc_reg + ACCW'(code);
                end
            end

            assign off_rd[gi*OFFW +: OFFW] = off_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adcout_reg    <= '0;
            valid_out_reg <= 1'b0;
        end else begin
            valid_out_reg <= valid_in;
            if (valid_in) begin
                adcout_reg <= bypass ? adcin : corr_word;
            end
        end
    end

    assign adcout    = adcout_reg;
    assign valid_out = valid_out_reg;
    assign cal_done  = cal_done_reg;

endmodule

// File: tb/tb_ti_adc_offset_cal.sv
// Scoreboard bench for ti_adc_offset_cal: expected corrected words are queued at drive
// time and compared as VALID_OUT words emerge; trims follow a bench-side model.
module tb_ti_adc_offset_cal;

    localparam int WAYS  = 8;
    localparam int BITS  = 9;
    localparam int OFFW  = 8;
    localparam int LOG2N = 4;
    localparam int WW    = WAYS * BITS;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [WW-1:0]     adcin = '0;
    logic              valid_in = 1'b0;
    logic              bypass = 1'b0;
    logic [WW-1:0]     adcout;
    logic              valid_out;
    logic              cal_start = 1'b0;
    logic [BITS-1:0]   cal_target = 9'd256;
    logic              cal_busy;
    logic              cal_done;
    logic              off_wr_en = 1'b0;
    logic [2:0]        off_wr_idx = '0;
    logic [OFFW-1:0]   off_wr_data = '0;
    logic [WAYS*OFFW-1:0] off_rd;

    ti_adc_offset_cal #(
        .WAYS(WAYS), .BITS(BITS), .OFFW(OFFW), .LOG2N(LOG2N)
    ) dut (
        .clk(clk), .rst(rst), .adcin(adcin), .valid_in(valid_in), .bypass(bypass),
        .adcout(adcout), .valid_out(valid_out), .cal_start(cal_start),
        .cal_target(cal_target), .cal_busy(cal_busy), .cal_done(cal_done),
        .off_wr_en(off_wr_en), .off_wr_idx(off_wr_idx), .off_wr_data(off_wr_data),
        .off_rd(off_rd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WW-1:0] sb[$];
    int model_off[WAYS];
    int pend_off[WAYS];
    bit cal_active = 1'b0;
    int start_cyc = 0;
    int exp_lat = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [WW-1:0] mkword(input int base, input int stepk);
        logic [WW-1:0] r;
        r = '0;
        for (int k = 0; k < WAYS; k++) r[k*BITS +: BITS] = BITS'(base + stepk * k);
        return r;
    endfunction

    function automatic logic [WW-1:0] exp_word(input logic [WW-1:0] w, input logic byp);
        logic [WW-1:0] r;
        int d;
        r = w;
        if (!byp) begin
            for (int k = 0; k < WAYS; k++) begin
                d = int'(w[k*BITS +: BITS]) - model_off[k];
                if (d < 0) d = 0;
                if (d > 511) d = 511;
                r[k*BITS +: BITS] = BITS'(d);
            end
        end
        return r;
    endfunction

    function automatic logic [WAYS*OFFW-1:0] pack_off();
        logic [WAYS*OFFW-1:0] r;
        for (int k = 0; k < WAYS; k++) r[k*OFFW +: OFFW] = OFFW'(model_off[k]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (sb.size() == 0) begin
                check_val("sb_underflow", 1, 0);
            end else begin
                logic [WW-1:0] e;
                e = sb.pop_front();
                check_val("adcout", adcout, e);
            end
        end
    end

    // One cycle of stimulus, driven on the falling edge.
    task automatic step(input logic [WW-1:0] w, input logic v, input logic byp,
                        input logic st, input logic we, input int idx, input int data);
        @(negedge clk);
        cyc++;
        if (cal_done) begin
            if (cal_active) begin
                check_val("cal_latency", cyc - start_cyc, exp_lat);
                check_val("busy_at_done", cal_busy, 0);
                for (int k = 0; k < WAYS; k++) model_off[k] = pend_off[k];
                cal_active = 1'b0;
                check_val("off_rd_cal", off_rd, pack_off());
            end else begin
                check_val("cal_done_spurious", 1, 0);
            end
        end
        adcin       = w;
        valid_in    = v;
        bypass      = byp;
        cal_start   = st;
        off_wr_en   = we;
        off_wr_idx  = 3'(idx);
        off_wr_data = OFFW'(data);
        if (v) sb.push_back(exp_word(w, byp));
        if (we && !cal_active && idx < WAYS) model_off[idx] = data;
        if (st && !cal_active) begin
            cal_active = 1'b1;
            start_cyc  = cyc;
        end
    endtask

    task automatic word_step(input logic [WW-1:0] w, input logic v, input logic byp);
        step(w, v, byp, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        valid_in = 1'b0;
        cal_start = 1'b0;
        off_wr_en = 1'b0;
        #1;
        check_val("rst_adcout", adcout, 0);
        check_val("rst_valid_out", valid_out, 0);
        check_val("rst_off_rd", off_rd, 0);
        check_val("rst_cal_busy", cal_busy, 0);
        check_val("rst_cal_done", cal_done, 0);
        sb.delete();
        for (int k = 0; k < WAYS; k++) model_off[k] = 0;
        cal_active = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cal(input logic [WW-1:0] w_a, input logic [WW-1:0] w_b,
                           input bit gaps, input int lat);
        exp_lat = lat;
        step(w_a, !gaps, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 80 && cal_active; i++) begin
            logic v;
            logic [WW-1:0] w;
            v = gaps ? (i % 2 == 0) : 1'b1;
            w = (i % 4 < 2) ? w_a : w_b;
            if (gaps && i == 5) step(w, v, 1'b0, 1'b1, 1'b1, 0, 99);
            else word_step(w, v, 1'b0);
            if (i == 0) check_val("busy_after_start", cal_busy, 1);
        end
        check_val("cal_complete", cal_active, 0);
    endtask

    initial begin
        logic [WW-1:0] w;
        logic [WW-1:0] w2;
        int d;

        for (int k = 0; k < WAYS; k++) begin
            model_off[k] = 0;
            pend_off[k]  = 0;
        end
        do_reset();

        // Mid-stream reset, then simple pass-through with zero trims.
        for (int i = 0; i < 4; i++) word_step(mkword(100, 1), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) word_step(mkword(100, 1), 1'b1, 1'b0);
        @(posedge clk); #1;
        check_val("post_rst_word", adcout, mkword(100, 1));

        // Saturation against hand-written trims.
        step('0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 20);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1, 1, -20);
        step('0, 1'b0, 1'b0, 1'b0, 1'b1, 2, -3);
        w = mkword(300, 0);
        w[0 +: BITS]  = 9'd5;
        w[9 +: BITS]  = 9'd500;
        w[18 +: BITS] = 9'd256;
        word_step(w, 1'b1, 1'b0);
        @(posedge clk); #1;
        check_val("off_rd_manual", off_rd, pack_off());
        check_val("sat_low", adcout[0 +: BITS], 0);
        check_val("sat_high", adcout[9 +: BITS], 511);
        check_val("neg_trim", adcout[18 +: BITS], 259);
        word_step(w, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_val("bypass", adcout, w);

        // Random traffic with occasional trim writes and bypass.
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < WAYS; k++) w[k*BITS +: BITS] = BITS'($urandom_range(0, 511));
            d = int'($urandom_range(0, 255));
            if (d >= 128) d = d - 256;
            step(w, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), 1'b0,
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, WAYS - 1)), d);
        end
        word_step('0, 1'b0, 1'b0);
        check_val("off_rd_random", off_rd, pack_off());

        // Calibration to the target mean.
        cal_target = 9'd256;
        for (int k = 0; k < WAYS; k++) pend_off[k] = -10 + 5 * k;
        run_cal(mkword(246, 5), mkword(246, 5), 1'b0, 18);
        for (int i = 0; i < 3; i++) word_step(mkword(246, 5), 1'b1, 1'b0);
        @(posedge clk); #1;
        check_val("cal_result_word", adcout, mkword(256, 0));

        // Trim clamp at both ends.
        w = mkword(256, 0);
        w[0 +: BITS] = 9'd511;
        w[9 +: BITS] = 9'd0;
        for (int k = 0; k < WAYS; k++) pend_off[k] = 0;
        pend_off[0] = 127;
        pend_off[1] = -128;
        run_cal(w, w, 1'b0, 18);
        for (int i = 0; i < 2; i++) word_step(w, 1'b1, 1'b0);

        // Valid gaps, plus ignored CAL_START/OFF_WR_EN during accumulation.
        cal_target = 9'd250;
        w  = mkword(250, 1);
        w2 = mkword(250, 1);
        w[0 +: BITS]  = 9'd250;
        w2[0 +: BITS] = 9'd262;
        pend_off[0] = 6;
        for (int k = 1; k < WAYS; k++) pend_off[k] = k;
        run_cal(w, w2, 1'b1, 33);
        for (int i = 0; i < 2; i++) word_step(w2, 1'b1, 1'b0);

        // Abort: reset halfway through accumulation wipes trims, no done pulse.
        step('0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 7);
        word_step('0, 1'b0, 1'b0);
        check_val("off3_written", off_rd[3*OFFW +: OFFW], 7);
        step(mkword(200, 3), 1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 8; i++) word_step(mkword(200, 3), 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 20; i++) word_step(mkword(200, 3), 1'b1, 1'b0);
        check_val("abort_off_rd", off_rd, 0);
        cal_target = 9'd256;
        for (int k = 0; k < WAYS; k++) pend_off[k] = -10 + 5 * k;
        run_cal(mkword(246, 5), mkword(246, 5), 1'b0, 18);
        for (int i = 0; i < 3; i++) word_step(mkword(246, 5), 1'b1, 1'b0);

        word_step('0, 1'b0, 1'b0);
        word_step('0, 1'b0, 1'b0);
        check_val("sb_drain", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
